// File: rtl/mac_pkg.sv
// Shared widths, sequencer state encoding and drain length for the
// dot-product sequencer and its MAC lane.
package mac_pkg;

  localparam int DATA_W       = 16;
  localparam int ACC_W        = 40;
  localparam int LEN_W        = 8;
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_seq_state_t;

endpackage

// File: rtl/mac_acc_lane.sv
// Registered signed 16x16 multiply feeding a wrapping accumulator.
// clr has priority over en; the product lands one edge before the accumulate.
module mac_acc_lane #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod;
  logic                     prod_vld;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      if (en) begin
        prod <= a * b;
      end
      prod_vld <= en;
      // sign-extend the product to the accumulator width; the add wraps
      if (prod_vld) begin
        acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
      end
    end
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product job sequencer: takes start+len, streams operand pairs through the
// MAC lane, drains the pipeline and presents the sum on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; accumulator holds the previous result
// RUN   | accepting operand pairs until the remaining count reaches zero
// DRAIN | fixed wait so the last product reaches the accumulator
// DONE  | result valid, waiting for res_ready
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int LEN_W  = mac_pkg::LEN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic        [LEN_W-1:0]  len,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] inputA,
  input  logic signed [DATA_W-1:0] inputB,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic        [ACC_W-1:0]  z
);

  mac_seq_state_t       state, state_nxt;
  logic [LEN_W-1:0]     cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 beat;
  logic                 job_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    beat      = 1'b0;
    job_clr   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          job_clr   = 1'b1;
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        beat     = in_valid;
        if (in_valid && cnt == LEN_W'(1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // remaining-beat and drain down-counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= len;
      end else if (beat) begin
        cnt <= cnt - LEN_W'(1);
      end
      if (state == RUN) begin
        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
    end
  end

  mac_acc_lane #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_lane (
    .clk  (clk),
    .reset(reset),
    .clr  (job_clr),
    .en   (beat),
    .a    (inputA),
    .b    (inputB),
    .acc  (z)
  );

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: directed and randomized jobs checked against a plain
// arithmetic dot-product model, plus latency, handshake and reset behaviour.
module tb_mac_dot_seq;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         len;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] inputA;
  logic signed [15:0] inputB;
  logic               res_valid;
  logic               res_ready;
  logic [39:0]        z;

  int total  = 0;
  int passed = 0;
  int beats  = 0;

  logic signed [15:0] opa [256];
  logic signed [15:0] opb [256];

  mac_dot_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inputA   (inputA),
    .inputB   (inputB),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .z        (z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) beats++;
  end

  function automatic logic [39:0] ref_dot(input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(opa[i]) * longint'(opb[i]);
    return s[39:0];
  endfunction

  // Runs one job from IDLE through the result handshake. All driving and
  // sampling happens on the falling edge.
  task automatic drive_job(input int n, input int gap_pct, input int hold,
                           input bit poke_start, output int lat, output bit tmo,
                           output logic [39:0] zv, output bit zstable,
                           output int nbeats, output bit ready_leak,
                           output bit busy_run);
    int idx, guard, b0;
    b0 = beats; tmo = 0; ready_leak = 0; zstable = 1;
    start = 1'b1; len = 8'(n);
    @(negedge clk);
    start = 1'b0;
    busy_run = busy && (in_ready == (n != 0));
    idx = 0; guard = 0;
    while (idx < n && guard < 4000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      inputA = opa[idx]; inputB = opb[idx];
      start = poke_start && idx == 1; len = 8'd2;
      if (in_valid && in_ready) idx++;
      @(negedge clk); guard++;
    end
    start = 1'b0;
    if (idx < n) tmo = 1;
    in_valid = 1'b1; inputA = 16'sh7fff; inputB = 16'sh7fff;
    lat = 1;
    while (!res_valid && lat < 50) begin
      if (in_ready) ready_leak = 1;
      @(negedge clk); lat++;
    end
    if (!res_valid) tmo = 1;
    in_valid = 1'b0;
    zv = z;
    for (int h = 0; h < hold; h++) begin
      start = poke_start && h == 0; len = 8'd2;
      @(negedge clk);
      if (z !== zv || !res_valid) zstable = 0;
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    nbeats = beats - b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; len = 8'd5; in_valid = 1'b1; res_ready = 1'b0;
    inputA = 16'sd3; inputB = 16'sd4;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid); else passed++;
    total++; if (z !== 40'd0) $display("FAIL reset_z got %h want 0", z); else passed++;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_basic;
    int lat, nb; bit tmo, zs, leak, br; logic [39:0] zv;
    opa[0] = 16'sd2; opb[0] = 16'sd3;
    opa[1] = 16'sd4; opb[1] = 16'sd5;
    opa[2] = -16'sd1; opb[2] = 16'sd7;
    drive_job(3, 0, 0, 0, lat, tmo, zv, zs, nb, leak, br);
    total++; if (tmo) $display("FAIL basic_timeout got timeout want none"); else passed++;
    total++; if (br !== 1'b1) $display("FAIL basic_busy_ready got %b want 1", br); else passed++;
    total++; if (zv !== 40'h00_0000_0013) $display("FAIL basic_z got %h want 0000000013", zv); else passed++;
    total++; if (lat != 3) $display("FAIL basic_latency got %0d want 3", lat); else passed++;
    total++; if (nb != 3) $display("FAIL basic_beats got %0d want 3", nb); else passed++;
    total++; if (leak) $display("FAIL basic_ready_after_last got 1 want 0"); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_idle_after got busy=%b want 0", busy); else passed++;
    total++; if (z !== 40'h13) $display("FAIL basic_z_kept got %h want 0000000013", z); else passed++;
  endtask

  task automatic test_zero_len;
    int lat, nb; bit tmo, zs, leak, br; logic [39:0] zv;
    drive_job(0, 0, 2, 0, lat, tmo, zv, zs, nb, leak, br);
    total++; if (tmo) $display("FAIL zero_timeout got timeout want none"); else passed++;
    total++; if (br !== 1'b1) $display("FAIL zero_busy_noready got %b want 1", br); else passed++;
    total++; if (lat != 1) $display("FAIL zero_latency got %0d want 1", lat); else passed++;
    total++; if (zv !== 40'd0) $display("FAIL zero_z got %h want 0", zv); else passed++;
    total++; if (nb != 0 || leak) $display("FAIL zero_no_beats got beats=%0d leak=%b want 0 0", nb, leak); else passed++;
  endtask

  task automatic test_worst_case;
    int lat, nb; bit tmo, zs, leak, br; logic [39:0] zv;
    for (int i = 0; i < 255; i++) begin opa[i] = -16'sd32768; opb[i] = -16'sd32768; end
    drive_job(255, 0, 0, 0, lat, tmo, zv, zs, nb, leak, br);
    total++; if (zv !== 40'h3F_C000_0000) $display("FAIL worst_z got %h want 3fc0000000", zv); else passed++;
    total++; if (nb != 255 || lat != 3) $display("FAIL worst_beats_lat got %0d/%0d want 255/3", nb, lat); else passed++;
  endtask

  task automatic test_backpressure;
    int lat, nb; bit tmo, zs, leak, br; logic [39:0] zv;
    for (int i = 0; i < 4; i++) begin opa[i] = 16'(i + 1); opb[i] = 16'(i + 1); end
    drive_job(4, 40, 5, 0, lat, tmo, zv, zs, nb, leak, br);
    total++; if (zv !== 40'd30) $display("FAIL bp_z got %0d want 30", zv); else passed++;
    total++; if (!zs) $display("FAIL bp_z_stable got unstable want stable"); else passed++;
    total++; if (nb != 4) $display("FAIL bp_beats got %0d want 4", nb); else passed++;
    total++; if (lat != 3) $display("FAIL bp_latency got %0d want 3", lat); else passed++;
  endtask

  task automatic test_ignored_start;
    int lat, nb; bit tmo, zs, leak, br; logic [39:0] zv, exp;
    for (int i = 0; i < 5; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
    exp = ref_dot(5);
    drive_job(5, 20, 3, 1, lat, tmo, zv, zs, nb, leak, br);
    total++; if (zv !== exp) $display("FAIL ign_z got %h want %h", zv, exp); else passed++;
    total++; if (nb != 5 || !zs) $display("FAIL ign_beats_stable got %0d/%b want 5/1", nb, zs); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ign_idle_after got busy=%b want 0", busy); else passed++;
    for (int i = 0; i < 2; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
    exp = ref_dot(2);
    drive_job(2, 0, 0, 0, lat, tmo, zv, zs, nb, leak, br);
    total++; if (zv !== exp) $display("FAIL ign_fresh_z got %h want %h", zv, exp); else passed++;
  endtask

  task automatic test_reset_mid_job;
    int lat, nb; bit tmo, zs, leak, br; logic [39:0] zv;
    start = 1'b1; len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1; inputA = 16'($urandom); inputB = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL rst_mid_ctrl got busy=%b rdy=%b vld=%b want 0 0 0", busy, in_ready, res_valid);
    else passed++;
    total++; if (z !== 40'd0) $display("FAIL rst_mid_z got %h want 0", z); else passed++;
    opa[0] = 16'sd3; opb[0] = -16'sd3;
    drive_job(1, 0, 0, 0, lat, tmo, zv, zs, nb, leak, br);
    total++; if (zv !== 40'hFF_FFFF_FFF7) $display("FAIL rst_next_z got %h want fffffffff7", zv); else passed++;
    total++; if (nb != 1 || lat != 3) $display("FAIL rst_next_beats_lat got %0d/%0d want 1/3", nb, lat); else passed++;
  endtask

  task automatic test_random_jobs;
    int lat, nb, n; bit tmo, zs, leak, br; logic [39:0] zv, exp;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
      exp = ref_dot(n);
      drive_job(n, 30, $urandom_range(0, 3), 0, lat, tmo, zv, zs, nb, leak, br);
      total++;
      if (tmo || zv !== exp || nb != n || lat != 3 || !zs || leak)
        $display("FAIL rand_job%0d got z=%h beats=%0d lat=%0d tmo=%b want z=%h beats=%0d lat=3",
                 j, zv, nb, lat, tmo, exp, n);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; res_ready = 1'b0;
    inputA = '0; inputB = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_worst_case();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_job();
    test_random_jobs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer that computes an N-element signed dot product on the team's 16×16→40-bit MAC datapath. It accepts a job (`start` + length), streams operand pairs in through a valid/ready handshake, clears and enables the accumulator at the right cycles, and returns the 40-bit sum through a valid/ready result port. It sits between an operand source (memory reader or host FIFO) and the result consumer. It replaces free-running MAC usage, where the accumulator is only cleared by reset.

## Interface
- `DATA_W`, 16: operand width, signed two's complement.
- `ACC_W`, 40: accumulator and result width.
- `LEN_W`, 8: job length counter width. Maximum N is 2^LEN_W−1.
- `clk` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: job request. Sampled only in IDLE.
- `len` in LEN_W: element count N. Sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1: an operand pair is present.
- `in_ready` out 1: equals (state == RUN).
- `inputA`, `inputB` in DATA_W each: operand pair. Consumed when `in_valid && in_ready`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `z` out ACC_W: dot-product result. Stable while `res_valid` is high.

## Operation
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start` with `len` ≠ 0: load the remaining-count register with `len`, clear the accumulator and the product register, go to RUN.
  - On `start` with `len` = 0: clear the accumulator and go straight to DONE with `z` = 0.
  - Any other input is ignored.
- RUN:
  - Each handshake beat registers the product `inputA*inputB` (signed, 2·DATA_W bits) and decrements the count.
  - On the beat that takes the count to 0, go to DRAIN.
  - Cycles with `in_valid` low add nothing.
- DRAIN:
  - Fixed 2 cycles, tracked by a drain counter. This lets the last product reach the accumulator.
  - Then go to DONE.
- DONE:
  - `res_valid` = 1 and `z` = accumulator.
  - On `res_ready`, go to IDLE.
  - `start` is ignored in DONE. A new job can start in the IDLE cycle that follows.
- Arithmetic:
  - The product is sign-extended to ACC_W bits, then added to the accumulator.
  - The sum wraps modulo 2^ACC_W.
  - Overflow is impossible for LEN_W ≤ 9. There is no overflow flag.
- `start` asserted in RUN, DRAIN or DONE is dropped. It is not queued.
- Reset in any state:
  - Next state is IDLE.
  - Accumulator, product register and counters are cleared.
  - Any in-flight job and result is discarded.

## Timing
- Reset values: `busy`=0, `in_ready`=0, `res_valid`=0, `z`=0.
- `start` sampled at edge t → `busy` and `in_ready` are high from t+1.
- Pipeline for a beat accepted at edge k:
  - Product register is updated at k.
  - Accumulator is updated at k+1.
- For the last beat, accepted at edge k:
  - DRAIN occupies the cycles after edges k and k+1.
  - `res_valid` is high after edge k+2. Result latency is 3 cycles from the last beat.
- Zero-length job: `res_valid` is high 1 cycle after `start` is sampled.
- Throughput: 1 pair per cycle. Full-rate job duration is N+3 cycles plus the result handshake.
- `in_ready` drops after the edge that accepts the final beat. No extra beat is ever consumed.
- `z` holds its value from `res_valid` rise until the handshake. `z` is not cleared on exit from DONE; it is cleared only by the next `start`.

## Structure
- `mac_pkg` holds:
  - the default widths DATA_W, ACC_W, LEN_W;
  - the state enum `mac_seq_state_t`;
  - the constant DRAIN_CYCLES = 2.
- One sub-module, `mac_acc_lane`:
  - Registered signed multiply plus accumulator.
  - Inputs: `clr` and `en`; `clr` wins over `en`.
  - Output: the accumulator value.
  - Instantiated once.
- The FSM and counters live in `mac_dot_seq`.

## Test plan
- Basic job: `len`=3, pairs (2,3), (4,5), (−1,7) at full rate → `z`=0x00_0000_0013. `res_valid` high 3 cycles after the third beat.
- Zero length: `start` with `len`=0 → `res_valid` the next cycle, `z`=0, `in_ready` never rises.
- Worst-case magnitude: `len`=255, all pairs (−32768, −32768) → `z`=0x3F_C000_0000.
- Backpressure:
  - Stimulus: `len`=4 with pairs (1,1), (2,2), (3,3), (4,4) and random `in_valid` gaps; hold `res_ready` low for 5 cycles.
  - Response: `z`=30, held stable while `res_ready` is low. Exactly 4 beats consumed.
- Ignored start:
  - Stimulus: pulse `start` with `len`=2 during RUN and again during DONE.
  - Response: no effect. The next job after returning to IDLE returns a fresh sum; accumulator residue is checked to be absent.
- Reset mid-job: assert `reset` after 2 of 5 beats → the next cycle shows IDLE, `busy`=0, `z`=0. A following job with `len`=1 and pair (3,−3) gives 0xFF_FFFF_FFF7.
